// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad, debounces whole frames and presents one decoded
// key at a time to the CPU as a memory-mapped input device.
//
// Parameters
//   SCAN_DIV : clock cycles each column stays driven (>= 4)
//   DEBOUNCE : identical frames needed to accept a press / empty frames
//              needed to accept a release (>= 1)
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   col[3:0]  out  column drive, active-low, one-cold
//   row[3:0]  in   row sense, active-low, asynchronous to clk
//   rd        in   single-cycle CPU read acknowledge
//   key_valid out  an unread key is held in key_code
//   key_code  out  last accepted key, col_index*4 + row_index
//   overrun   out  sticky: a key was accepted while key_valid was still 1
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  input  logic       rd,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       overrun
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FR_EMPTY  = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_e;

  // Classify a frame snapshot by how many keys it shows pressed.
  function automatic frame_e classify_frame(input logic [15:0] frame);
    logic [4:0] n;
    frame_e     cls;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, frame[i]};
    end
    if (n == 5'd0) begin
      cls = FR_EMPTY;
    end else if (n == 5'd1) begin
      cls = FR_SINGLE;
    end else begin
      cls = FR_MULTI;
    end
    return cls;
  endfunction

  // Index of the lowest set bit; only meaningful for a SINGLE frame.
  function automatic logic [3:0] lowest_index(input logic [15:0] frame);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (frame[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Registers
  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      snap_q, snap_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             overrun_q, overrun_d;

  // Combinational helpers
  logic [3:0]       pressed_s;
  logic             sample_s;
  logic             frame_done_s;
  logic [15:0]      frame_s;
  frame_e           frame_cls_s;
  logic [3:0]       frame_key_s;
  logic             accept_s;
  logic [CNT_W-1:0] press_next_s;
  logic [CNT_W-1:0] rel_next_s;

  // Two-flop synchronizer for the asynchronous row lines.
  always_comb begin
    row_meta_d = row;
    row_sync_d = row_meta_q;
  end

  // Column dwell divider, column rotation and per-column frame snapshot.
  always_comb begin
    div_d     = div_q;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    snap_d    = snap_q;
    pressed_s = ~row_sync_q;
    sample_s  = (div_q == DIV_LAST);
    if (sample_s) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(4'b0001 << col_idx_d);
      case (col_idx_q)
        2'd0:    snap_d[3:0]   = pressed_s;
        2'd1:    snap_d[7:4]   = pressed_s;
        2'd2:    snap_d[11:8]  = pressed_s;
        2'd3:    snap_d[15:12] = pressed_s;
        default: snap_d        = snap_q;
      endcase
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // The column-3 nibble is merged straight from the synchronizer so the
  // frame is judged in the same cycle it completes.
  always_comb begin
    frame_done_s = sample_s && (col_idx_q == 2'd3);
    frame_s      = {pressed_s, snap_q[11:0]};
    frame_cls_s  = classify_frame(frame_s);
    frame_key_s  = lowest_index(frame_s);
  end

  // Debounce FSM: next state, counters and accept strobe, once per frame.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    press_cnt_d  = press_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    accept_s     = 1'b0;
    press_next_s = press_cnt_q + CNT_ONE;
    rel_next_s   = rel_cnt_q + CNT_ONE;
    if (frame_done_s) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_cls_s == FR_SINGLE) begin
            cand_d = frame_key_s;
            if (DEBOUNCE == 1) begin
              state_d     = ST_HELD;
              press_cnt_d = CNT_MAX;
              rel_cnt_d   = '0;
              accept_s    = 1'b1;
            end else begin
              state_d     = ST_CAND;
              press_cnt_d = CNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CAND: begin
          if (frame_cls_s == FR_SINGLE) begin
            if (frame_key_s == cand_q) begin
              press_cnt_d = press_next_s;
              if (press_next_s == CNT_MAX) begin
                state_d   = ST_HELD;
                rel_cnt_d = '0;
                accept_s  = 1'b1;
              end else begin
                state_d = ST_CAND;
              end
            end else begin
              // A different single key restarts the candidate.
              cand_d      = frame_key_s;
              press_cnt_d = CNT_ONE;
            end
          end else begin
            state_d     = ST_IDLE;
            press_cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (frame_cls_s == FR_EMPTY) begin
            if (rel_next_s == CNT_MAX) begin
              state_d     = ST_IDLE;
              rel_cnt_d   = '0;
              press_cnt_d = '0;
            end else begin
              rel_cnt_d = rel_next_s;
            end
          end else begin
            // Any key still down (or a new one) keeps the hold alive.
            rel_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          press_cnt_d = '0;
          rel_cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // CPU-facing holding register; an accept takes priority over rd.
  always_comb begin
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = overrun_q;
    if (accept_s) begin
      key_valid_d = 1'b1;
      key_code_d  = frame_key_s;
      if (rd) begin
        overrun_d = 1'b0;
      end else if (key_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (rd && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q  <= 4'b0000;
      row_sync_q  <= 4'b0000;
      div_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      snap_q      <= 16'h0000;
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      press_cnt_q <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      overrun_q   <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      press_cnt_q <= press_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle
// frame). A keypad model pulls row[r] low while col[c] is low for every
// pressed key (c,r). Key masks use bit index c*4+r. Cycle numbers in the
// comments count rising edges after reset release; frames end at 16*n.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic        clk;
  logic        reset;
  logic        rd;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        overrun;
  logic [15:0] pressed;

  int num_checks = 0;
  int num_errors = 0;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .row      (row),
    .rd       (rd),
    .key_valid(key_valid),
    .key_code (key_code),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && pressed[c*4 + r]) begin
          row[r] = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset with the given keys already held; returns just before edge 1.
  task automatic start_run(input logic [15:0] mask);
    rd      = 1'b0;
    pressed = mask;
    reset   = 1'b0;
    #12;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    rd      = 1'b0;
    pressed = 16'h0000;
    #3;

    // ---- Reset and scan ----
    reset = 1'b0;
    #12;
    check_eq("rst_col",   16'(col), 16'h000E);
    check_eq("rst_valid", 16'(key_valid), 16'h0000);
    check_eq("rst_code",  16'(key_code), 16'h0000);
    check_eq("rst_ovr",   16'(overrun), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    check_eq("scan_c0_start", 16'(col), 16'h000E);
    tick(3);
    check_eq("scan_c0_end", 16'(col), 16'h000E);
    tick(1);
    check_eq("scan_c1", 16'(col), 16'h000D);
    tick(4);
    check_eq("scan_c2", 16'(col), 16'h000B);
    tick(4);
    check_eq("scan_c3", 16'(col), 16'h0007);
    tick(4);
    check_eq("scan_wrap", 16'(col), 16'h000E);
    check_eq("scan_valid", 16'(key_valid), 16'h0000);

    // ---- Clean press of (2,1) -> code 9 ----
    start_run(16'h0200);
    tick(31);
    check_eq("press_early", 16'(key_valid), 16'h0000);
    tick(1);
    check_eq("press_valid", 16'(key_valid), 16'h0001);
    check_eq("press_code",  16'(key_code), 16'h0009);
    check_eq("press_ovr",   16'(overrun), 16'h0000);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    check_eq("press_rd_valid", 16'(key_valid), 16'h0000);
    check_eq("press_rd_code",  16'(key_code), 16'h0009);
    tick(47);
    check_eq("press_no_repeat", 16'(key_valid), 16'h0000);
    pressed = 16'h0000;

    // ---- Bounce: (0,3) for one frame, then a real press ----
    start_run(16'h0000);
    tick(16);
    pressed = 16'h0008;
    tick(16);
    pressed = 16'h0000;
    check_eq("bounce_valid_a", 16'(key_valid), 16'h0000);
    tick(32);
    check_eq("bounce_valid_b", 16'(key_valid), 16'h0000);
    pressed = 16'h0008;
    tick(16);
    check_eq("bounce_idle_1frame", 16'(key_valid), 16'h0000);
    tick(16);
    check_eq("bounce_repress_valid", 16'(key_valid), 16'h0001);
    check_eq("bounce_repress_code",  16'(key_code), 16'h0003);
    pressed = 16'h0000;

    // ---- Multi-key: (1,0) + (3,2) for 4 frames ----
    start_run(16'h4010);
    tick(32);
    check_eq("multi_valid_2f", 16'(key_valid), 16'h0000);
    tick(32);
    check_eq("multi_valid_4f", 16'(key_valid), 16'h0000);
    pressed = 16'h0000;

    // ---- Overrun ----
    start_run(16'h0008);
    tick(32);
    check_eq("ovr_first_valid", 16'(key_valid), 16'h0001);
    check_eq("ovr_first_code",  16'(key_code), 16'h0003);
    pressed = 16'h0000;
    tick(32);
    pressed = 16'h1000;
    tick(32);
    check_eq("ovr_code",  16'(key_code), 16'h000C);
    check_eq("ovr_valid", 16'(key_valid), 16'h0001);
    check_eq("ovr_flag",  16'(overrun), 16'h0001);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    check_eq("ovr_rd_valid", 16'(key_valid), 16'h0000);
    check_eq("ovr_rd_flag",  16'(overrun), 16'h0000);
    check_eq("ovr_rd_code",  16'(key_code), 16'h000C);
    pressed = 16'h0000;
    tick(31);
    pressed = 16'h0008;
    tick(32);
    check_eq("ovr2_first_code", 16'(key_code), 16'h0003);
    check_eq("ovr2_first_ovr",  16'(overrun), 16'h0000);
    pressed = 16'h0000;
    tick(32);
    pressed = 16'h1000;
    tick(31);
    check_eq("ovr2_pre_valid", 16'(key_valid), 16'h0001);
    check_eq("ovr2_pre_code",  16'(key_code), 16'h0003);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    check_eq("ovr2_acc_valid", 16'(key_valid), 16'h0001);
    check_eq("ovr2_acc_code",  16'(key_code), 16'h000C);
    check_eq("ovr2_acc_flag",  16'(overrun), 16'h0000);
    tick(1);
    check_eq("ovr2_hold_valid", 16'(key_valid), 16'h0001);
    pressed = 16'h0000;

    // ---- Reset mid-candidate: (1,1) -> code 5 ----
    start_run(16'h0008);
    tick(32);
    check_eq("mid_pre_valid", 16'(key_valid), 16'h0001);
    pressed = 16'h0000;
    tick(32);
    pressed = 16'h0020;
    tick(20);
    check_eq("mid_pre_col", 16'(col), 16'h000D);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_col",   16'(col), 16'h000E);
    check_eq("mid_rst_valid", 16'(key_valid), 16'h0000);
    check_eq("mid_rst_code",  16'(key_code), 16'h0000);
    check_eq("mid_rst_ovr",   16'(overrun), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    tick(16);
    check_eq("mid_after_1f", 16'(key_valid), 16'h0000);
    tick(15);
    check_eq("mid_before_2f", 16'(key_valid), 16'h0000);
    tick(1);
    check_eq("mid_valid", 16'(key_valid), 16'h0001);
    check_eq("mid_code",  16'(key_code), 16'h0005);
    pressed = 16'h0000;

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the board's seven-segment display driver. The display block drives digit anodes and reads nothing back; this block drives the 4×4 keypad column lines, reads the row lines, debounces the result and presents one decoded key at a time to the processor. It sits beside `Display` under `Pipeline` as a memory-mapped input device: the CPU reads `key_code` and pulses `rd` to acknowledge it.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column stays driven (dwell). Minimum 4.
- `DEBOUNCE`, default 4: consecutive identical frames needed to accept a press, and consecutive empty frames needed to accept a release. Minimum 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `col`  out  4  column drive, active-low, one-cold. Column c is driven when `col[c]` = 0.
- `row`  in  4  row sense, active-low, pulled up externally, asynchronous to `clk`.
- `rd`  in  1  single-cycle CPU read acknowledge.
- `key_valid`  out  1  an unread key is held in `key_code`.
- `key_code`  out  4  last accepted key, equal to col_index*4 + row_index.
- `overrun`  out  1  sticky flag: a key was accepted while `key_valid` was already 1.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Divider counts 0..SCAN_DIV-1. On wrap, the column index advances 0→1→2→3→0, and `col` = ~(1 << index).
- Sample point: the cycle where divider = SCAN_DIV-1. At that cycle the synchronized row bits for the current column are stored in the 16-bit frame snapshot at bits [4c+3:4c], with a pressed key stored as 1.
- A frame completes at the sample of column 3. Each completed frame is classified as one of:
  - EMPTY: 0 bits set.
  - SINGLE(k): exactly 1 bit set, k is its index.
  - MULTI: 2 or more bits set.
- FSM, evaluated once per completed frame:
  - IDLE:
    - SINGLE(k) → CAND; candidate = k, count = 1. If DEBOUNCE = 1, go directly to HELD and accept k.
    - EMPTY or MULTI → stay in IDLE.
  - CAND:
    - SINGLE(same k) → count+1. When count reaches DEBOUNCE, go to HELD and accept k.
    - SINGLE(other k') → stay in CAND; candidate = k', count = 1.
    - EMPTY or MULTI → IDLE.
  - HELD:
    - EMPTY → release count+1. When it reaches DEBOUNCE, go to IDLE.
    - SINGLE or MULTI → release count = 0, stay in HELD.
    - A held key is never re-reported. A second key pressed while in HELD is ignored.
- Accept k, as registered updates:
  - `key_code` ← k.
  - `key_valid` ← 1.
  - If `key_valid` was already 1 and `rd` is not asserted that cycle, `overrun` ← 1.
- `rd` with no accept in the same cycle: `key_valid` ← 0 and `overrun` ← 0 on the next edge. `key_code` holds its value.
- `rd` and accept in the same cycle: the accept wins. `key_valid` stays 1, `key_code` = k, `overrun` ← 0.
- `rd` while `key_valid` = 0: no effect.
- Widths:
  - Divider: $clog2(SCAN_DIV).
  - Press and release counters: $clog2(DEBOUNCE+1), saturating at DEBOUNCE.

## Timing
- Reset values, applied asynchronously when `reset` = 0:
  - `col` = 4'b1110.
  - `key_valid` = 0, `key_code` = 0, `overrun` = 0.
  - FSM = IDLE, all counters = 0, snapshot = 0, synchronizer flops = 0.
- Reset mid-operation aborts any pending candidate. After release, scanning restarts at column 0 with a full dwell.
- Frame length is 4×SCAN_DIV cycles.
- `key_valid` rises on the clock edge following the column-3 sample of the DEBOUNCE-th qualifying frame.
- Row settling: `col` changes at the dwell boundary, and the sample is taken SCAN_DIV-1 cycles later. This covers the 2-cycle synchronizer latency whenever SCAN_DIV ≥ 4.
- Outputs are registered, with no combinational path from `row` or `rd` to any output.

## Test plan
Benches use SCAN_DIV=4 and DEBOUNCE=2, giving a 16-cycle frame. The keypad model drives `row[r]` = 0 while `col[c]` = 0 for each pressed key (c,r).
- Reset and scan: hold `reset` low, then release. `col` = 1110 for 4 cycles, then 1101, 1011, 0111, and back to 1110. `key_valid` = 0 throughout.
- Clean press: hold key (2,1) for 5 frames. `key_valid` = 1 and `key_code` = 9 one cycle after the end of the 2nd frame. Pulse `rd` → `key_valid` = 0 next cycle. No second report while the key stays held.
- Bounce: press (0,3) for exactly one frame, then release. `key_valid` stays 0 and the FSM returns to IDLE.
- Multi-key: hold (1,0) and (3,2) together for 4 frames. No report is made.
- Overrun: press (0,3) → code 3 accepted. Release for 2 or more frames, then press (3,0) with no `rd`. Result: `key_code` = 12, `overrun` = 1. One `rd` clears both `key_valid` and `overrun`. Repeat with `rd` pulsed in the accept cycle: `key_valid` = 1 and `overrun` = 0.
- Reset mid-candidate: press (1,1), assert `reset` after frame 1. All outputs return to their reset values immediately. After release, a full 2-frame press is again required before `key_code` = 5 is reported.
